amba_axi4_lite_regfile: RTL
===========================

Name: amba_axi4_lite_regfile

Overview:
Parametrised AXI4-Lite slave register file with NUM_REGS word registers, byte-strobe writes and independent AW/W acceptance. Some registers can be read-only and return hardware inputs. Accesses to unmapped or read-only locations return SLVERR. It sits behind the AXI4-Lite bus as the generic control/status block for datapath units such as the adder.

Parameters:
SIZE_WORD, 32, data width in bits (multiple of 8)
SIZE_STRB, SIZE_WORD/8, write strobe width
SIZE_ADDR, 32, address width
NUM_REGS, 8, number of word registers (>=1)
BASE_ADDR, 0, byte address of register 0 (word aligned)
RO_MASK, 0 (NUM_REGS bits), bit i = 1 makes register i read-only

Ports:
ACLK  in  1  clock
ARSTn  in  1  asynchronous active-low reset
AWVALID/AWREADY  in/out  1  write address handshake
AWADDR  in  SIZE_ADDR  write byte address
AWPROT  in  3  ignored
WVALID/WREADY  in/out  1  write data handshake
WDATA  in  SIZE_WORD  write data
WSTRB  in  SIZE_STRB  byte lane enables
BVALID/BREADY  out/in  1  write response handshake
BRESP  out  2  axi4_resp_el
ARVALID/ARREADY  in/out  1  read address handshake
ARADDR  in  SIZE_ADDR  read byte address
ARPROT  in  3  ignored
RVALID/RREADY  out/in  1  read data handshake
RDATA  out  SIZE_WORD  read data
RRESP  out  2  axi4_resp_el
reg_q  out  NUM_REGS*SIZE_WORD  register contents; register i at bits [i*SIZE_WORD +: SIZE_WORD]
ro_d  in  NUM_REGS*SIZE_WORD  hardware values returned for read-only registers
wr_pulse  out  NUM_REGS  one-cycle strobe on commit of register i

Behaviour:
- Single clock ACLK. Reset is asynchronous and active-low on ARSTn.
- While ARSTn=0:
  - All registers = 0.
  - AWREADY, WREADY, ARREADY, BVALID, RVALID, wr_pulse = 0.
  - BRESP = RRESP = OKAY; RDATA = 0.
- All READY/VALID outputs are registered. The READYs rise on the first ACLK edge after reset release.
- Address decode:
  - idx = (ADDR - BASE_ADDR) >> log2(SIZE_STRB); the low address bits are ignored.
  - An address is mapped iff ADDR >= BASE_ADDR and idx < NUM_REGS.
- Write FSM states: W_IDLE, W_RESP.
  - W_IDLE: AWREADY = !aw_full and WREADY = !w_full. A handshake latches AWADDR or WDATA/WSTRB into the aw or w holding buffer. AW and W may arrive in either order or in the same cycle.
  - W_IDLE with both buffers full for one cycle: commit on the next edge and enter W_RESP with BVALID=1.
  - Commit, mapped and not RO: each byte lane k with WSTRB[k]=1 is written. wr_pulse[idx]=1 for exactly that cycle if any strobe is set. BRESP=OKAY.
  - Commit, unmapped or RO: no register changes, no wr_pulse, BRESP=SLVERR.
  - WSTRB=0: no change, no pulse, BRESP=OKAY.
  - W_RESP: AWREADY = WREADY = 0. BVALID and BRESP are held until BREADY. On the handshake edge the buffers clear, BVALID=0, the state returns to W_IDLE and the READYs return the next cycle.
  - Latency: 2 cycles from the later of the AW/W handshakes to BVALID.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. On an AR handshake, RDATA/RRESP are registered and RVALID=1 on the next cycle (1-cycle latency). The FSM enters R_DATA with ARREADY=0.
  - RDATA source: RW register gives the register value; RO register gives ro_d sampled at the AR handshake; unmapped gives 0 with RRESP=SLVERR.
  - RDATA and RRESP stay stable until the RVALID&&RREADY edge, then the FSM returns to R_IDLE.
- Read and write paths are fully independent and may be active in the same cycle.
  - A read sampled on the same edge as a write commit to the same register returns the pre-write value.
- AWPROT and ARPROT have no effect.
- Reset asserted mid-transaction aborts it immediately. Buffers clear, no commit occurs, and the next transaction starts clean.

Test Plan:
- Reset then AW(0x4) and W(0xDEADBEEF, STRB=0xF) in the same cycle, BREADY=1 -> BVALID 2 cycles later with OKAY; wr_pulse[1] for one cycle; reg_q[1]=0xDEADBEEF; read 0x4 -> RDATA=0xDEADBEEF, OKAY, RVALID 1 cycle after AR.
- W first (0x12345678, STRB=0x5), AW(0x8) 3 cycles later, reg2 previously 0xFFFFFFFF -> WREADY low after the W handshake; BRESP OKAY; reg_q[2]=0xFF34FF78.
- RO_MASK=0x01, ro_d[0]=0xCAFE0001: write 0x0 -> SLVERR, no wr_pulse, reg_q[0] unchanged; read 0x0 -> 0xCAFE0001, OKAY.
- Unmapped: write 0x20 and read 0x20 (NUM_REGS=8) -> BRESP=SLVERR and RRESP=SLVERR, RDATA=0, no register change.
- Backpressure: BREADY=0 and RREADY=0 for 5 cycles -> BVALID/BRESP and RVALID/RDATA held stable; AWREADY, WREADY, ARREADY stay 0 until the handshake; second transactions are accepted afterwards.
- Assert ARSTn=0 after the AW handshake but before W -> all outputs reset asynchronously; a subsequent W-only transfer produces no BVALID until a new AW arrives.

Source files
------------

// File: rtl/amba_axi4_lite_regfile.sv
// AXI4-Lite slave register file: NUM_REGS word registers with byte strobes,
// optional read-only registers mirroring hardware inputs, SLVERR on bad access.

module amba_axi4_lite_regfile_reg #(
  parameter int SIZE_WORD = 32,
  parameter int SIZE_STRB = SIZE_WORD/8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [SIZE_STRB-1:0] strb,
  input  logic [SIZE_WORD-1:0] wdata,
  output logic [SIZE_WORD-1:0] q,
  output logic                 pulse
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= we && (|strb);
      for (int k = 0; k < SIZE_STRB; k++)
        if (we && strb[k]) q[k*8 +: 8] <= wdata[k*8 +: 8];
    end
  end
endmodule

module amba_axi4_lite_regfile #(
  parameter int                   SIZE_WORD = 32,
  parameter int                   SIZE_STRB = SIZE_WORD/8,
  parameter int                   SIZE_ADDR = 32,
  parameter int                   NUM_REGS  = 8,
  parameter logic [SIZE_ADDR-1:0] BASE_ADDR = '0,
  parameter logic [NUM_REGS-1:0]  RO_MASK   = '0
) (
  input  logic                          ACLK,
  input  logic                          ARSTn,
  input  logic                          AWVALID,
  output logic                          AWREADY,
  input  logic [SIZE_ADDR-1:0]          AWADDR,
  input  logic [2:0]                    AWPROT,
  input  logic                          WVALID,
  output logic                          WREADY,
  input  logic [SIZE_WORD-1:0]          WDATA,
  input  logic [SIZE_STRB-1:0]          WSTRB,
  output logic                          BVALID,
  input  logic                          BREADY,
  output logic [1:0]                    BRESP,
  input  logic                          ARVALID,
  output logic                          ARREADY,
  input  logic [SIZE_ADDR-1:0]          ARADDR,
  input  logic [2:0]                    ARPROT,
  output logic                          RVALID,
  input  logic                          RREADY,
  output logic [SIZE_WORD-1:0]          RDATA,
  output logic [1:0]                    RRESP,
  output logic [NUM_REGS*SIZE_WORD-1:0] reg_q,
  input  logic [NUM_REGS*SIZE_WORD-1:0] ro_d,
  output logic [NUM_REGS-1:0]           wr_pulse
);
  typedef enum logic [1:0] {OKAY, EXOKAY, SLVERR, DECERR} axi4_resp_el;
  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  localparam int                   AL   = $clog2(SIZE_STRB);
  localparam int                   IW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [SIZE_ADDR-1:0] NREG = SIZE_ADDR'(NUM_REGS);

  function automatic logic [SIZE_ADDR-1:0] word_of(input logic [SIZE_ADDR-1:0] a);
    return (a - BASE_ADDR) >> AL;
  endfunction

  logic [NUM_REGS-1:0][SIZE_WORD-1:0] regs, ro_arr;
  assign reg_q  = regs;
  assign ro_arr = ro_d;

  logic unused_prot;
  assign unused_prot = ^{AWPROT, ARPROT};

  // ---------------- write path ----------------
  wstate_e              w_state, w_state_n;
  logic                 aw_full, aw_full_n, w_full, w_full_n;
  logic                 awready_q, awready_n, wready_q, wready_n, bvalid_q, bvalid_n;
  axi4_resp_el          bresp_q, bresp_n;
  logic [SIZE_ADDR-1:0] aw_addr, w_word;
  logic [SIZE_WORD-1:0] w_data;
  logic [SIZE_STRB-1:0] w_strb;
  logic [IW-1:0]        w_idx;
  logic                 w_err, commit;

  assign w_word = word_of(aw_addr);
  assign w_idx  = w_word[IW-1:0];
  assign w_err  = !((aw_addr >= BASE_ADDR) && (w_word < NREG)) || RO_MASK[w_idx];

  always_comb begin
    w_state_n = w_state;
    aw_full_n = aw_full;
    w_full_n  = w_full;
    bvalid_n  = bvalid_q;
    bresp_n   = bresp_q;
    commit    = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (AWVALID && awready_q) aw_full_n = 1'b1;
        if (WVALID && wready_q)   w_full_n  = 1'b1;
        // Commit only off registered full flags so both halves are stable.
        if (aw_full && w_full) begin
          commit    = 1'b1;
          w_state_n = W_RESP;
          bvalid_n  = 1'b1;
          bresp_n   = w_err ? SLVERR : OKAY;
        end
      end
      W_RESP: if (BREADY) begin
        aw_full_n = 1'b0;
        w_full_n  = 1'b0;
        bvalid_n  = 1'b0;
        w_state_n = W_IDLE;
      end
      default: w_state_n = W_IDLE;
    endcase
    awready_n = (w_state_n == W_IDLE) && !aw_full_n;
    wready_n  = (w_state_n == W_IDLE) && !w_full_n;
  end

  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      w_state   <= W_IDLE;
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      aw_addr   <= '0;
      w_data    <= '0;
      w_strb    <= '0;
    end else begin
      w_state   <= w_state_n;
      aw_full   <= aw_full_n;
      w_full    <= w_full_n;
      awready_q <= awready_n;
      wready_q  <= wready_n;
      bvalid_q  <= bvalid_n;
      bresp_q   <= bresp_n;
      if (AWVALID && awready_q) aw_addr <= AWADDR;
      if (WVALID && wready_q) begin
        w_data <= WDATA;
        w_strb <= WSTRB;
      end
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    amba_axi4_lite_regfile_reg #(.SIZE_WORD(SIZE_WORD), .SIZE_STRB(SIZE_STRB)) u_reg (
      .clk   (ACLK),
      .rst_n (ARSTn),
      .we    (commit && !w_err && (w_idx == IW'(i))),
      .strb  (w_strb),
      .wdata (w_data),
      .q     (regs[i]),
      .pulse (wr_pulse[i])
    );
  end

  // ---------------- read path ----------------
  rstate_e              r_state, r_state_n;
  logic                 arready_q, arready_n, rvalid_q, rvalid_n, ar_hs;
  logic [SIZE_ADDR-1:0] r_word;
  logic [IW-1:0]        r_idx;
  logic [SIZE_WORD-1:0] rdata_q, rdata_n;
  axi4_resp_el          rresp_q, rresp_n;

  assign ar_hs  = ARVALID && arready_q;
  assign r_word = word_of(ARADDR);
  assign r_idx  = r_word[IW-1:0];

  always_comb begin
    rdata_n = '0;
    rresp_n = SLVERR;
    if ((ARADDR >= BASE_ADDR) && (r_word < NREG)) begin
      rresp_n = OKAY;
      rdata_n = RO_MASK[r_idx] ? ro_arr[r_idx] : regs[r_idx];
    end
  end

  always_comb begin
    r_state_n = r_state;
    rvalid_n  = rvalid_q;
    case (r_state)
      R_IDLE: if (ar_hs) begin
        r_state_n = R_DATA;
        rvalid_n  = 1'b1;
      end
      R_DATA: if (RREADY) begin
        r_state_n = R_IDLE;
        rvalid_n  = 1'b0;
      end
      default: r_state_n = R_IDLE;
    endcase
    arready_n = (r_state_n == R_IDLE);
  end

  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      r_state   <= r_state_n;
      arready_q <= arready_n;
      rvalid_q  <= rvalid_n;
      if (ar_hs) begin
        rdata_q <= rdata_n;
        rresp_q <= rresp_n;
      end
    end
  end

  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
endmodule
